// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
//
// Avalon-MM read master that walks a contiguous (wrapping) word-address range
// of one BRAM port and re-emits the words as a valid/ready stream.
//
// The BRAM read port has a fixed RD_LAT-cycle registered latency. Every read
// is tagged in a shift register that runs alongside the BRAM pipeline. When a
// tag leaves the shift register, the matching word is on bram_readdata and is
// pushed into a small show-ahead FIFO. New reads are only issued while every
// outstanding read still has a FIFO slot, so backpressure never drops a word.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake; cmd_addr = first word, cmd_len = count
//                     (0 .. 2^AWIDTH, 0 is accepted and ignored)
//   bram_*            Avalon-MM read master towards the BRAM
//                     (write/byteenable/clken are tied off)
//   out_data/valid/   output stream; out_last marks the final word of
//   ready/last        each command
//   busy              high while a command is in progress
// -----------------------------------------------------------------------------
module bram_stream_reader #(
    parameter int AWIDTH     = 9,
    parameter int DWIDTH     = 512,
    parameter int BEWIDTH    = 64,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [AWIDTH-1:0]   cmd_addr,
    input  logic [AWIDTH:0]     cmd_len,

    output logic [AWIDTH-1:0]   bram_address,
    output logic                bram_chipselect,
    output logic                bram_write,
    output logic [BEWIDTH-1:0]  bram_byteenable,
    output logic                bram_clken,
    input  logic [DWIDTH-1:0]   bram_readdata,

    output logic [DWIDTH-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,

    output logic                busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic [AWIDTH-1:0]    addr;
    logic [AWIDTH:0]      remaining;
    logic                 issue_last;   // qualifies the read currently on the bus

    // Latency tags: stage 0 follows the read on the bus by one cycle, so the
    // tag in stage RD_LAT-1 lines up with its word on bram_readdata.
    logic [RD_LAT-1:0]    tag_valid;
    logic [RD_LAT-1:0]    tag_last;

    logic [DWIDTH-1:0]    fifo_data [FIFO_DEPTH];
    logic                 fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     fifo_count;

    logic                 push;
    logic                 pop;
    logic [OCC_W-1:0]     occupancy;
    logic                 can_issue;

    // The BRAM is only ever read.
    assign bram_write      = 1'b0;
    assign bram_byteenable = '1;
    assign bram_clken      = 1'b1;

    // ------------------------------------------------------------------
    // Credit accounting
    // ------------------------------------------------------------------
    // occupancy = reads on the bus + reads in the BRAM pipeline + FIFO
    // entries. Every one of them will end up in the FIFO, so a new read is
    // only allowed while that total stays below FIFO_DEPTH. A pop this cycle
    // frees its slot at the same edge the new read is registered, so it is
    // credited immediately; that keeps one word per cycle streaming.
    always_comb begin
        occupancy = OCC_W'(fifo_count) + OCC_W'(bram_chipselect);
        for (int i = 0; i < RD_LAT; i++) begin
            occupancy = occupancy + OCC_W'(tag_valid[i]);
        end
    end

    assign can_issue = (occupancy - OCC_W'(pop)) < OCC_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Control FSM (all outputs registered)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            addr            <= '0;
            remaining       <= '0;
            cmd_ready       <= 1'b1;
            busy            <= 1'b0;
            bram_chipselect <= 1'b0;
            bram_address    <= '0;
            issue_last      <= 1'b0;
        end else begin
            bram_chipselect <= 1'b0;
            issue_last      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr      <= cmd_addr;
                        remaining <= cmd_len;
                        // A zero-length command is consumed without effect.
                        if (cmd_len != '0) begin
                            state     <= ISSUE;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (can_issue) begin
                        bram_chipselect <= 1'b1;
                        bram_address    <= addr;
                        issue_last      <= (remaining == (AWIDTH+1)'(1));
                        addr            <= addr + 1'b1;   // wraps modulo 2^AWIDTH
                        remaining       <= remaining - 1'b1;
                        if (remaining == (AWIDTH+1)'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Latency tag shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_valid <= '0;
            tag_last  <= '0;
        end else begin
            tag_valid[0] <= bram_chipselect;
            tag_last[0]  <= bram_chipselect & issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
        end
    end

    assign push = tag_valid[RD_LAT-1];

    // ------------------------------------------------------------------
    // Show-ahead output FIFO
    // ------------------------------------------------------------------
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = fifo_data[rd_ptr];
    // Masked so a stale flag in an empty slot never shows on the port.
    assign out_last  = out_valid & fifo_last[rd_ptr];

    // Storage carries no reset: contents are meaningless while count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bram_readdata;
            fifo_last[wr_ptr] <= tag_last[RD_LAT-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// -----------------------------------------------------------------------------
// Testbench for bram_stream_reader: BRAM model with a two-stage registered
// read, scoreboard queues of expected read addresses and stream words filled
// when each command is driven and drained as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_bram_stream_reader;

    localparam int AW     = 9;
    localparam int DW     = 512;
    localparam int BW     = 64;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_addr;
    logic [AW:0]     cmd_len;
    logic [AW-1:0]   bram_address;
    logic            bram_chipselect;
    logic            bram_write;
    logic [BW-1:0]   bram_byteenable;
    logic            bram_clken;
    logic [DW-1:0]   bram_readdata;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;

    always #5 clk = ~clk;

    bram_stream_reader #(
        .AWIDTH(AW), .DWIDTH(DW), .BEWIDTH(BW), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .bram_address(bram_address), .bram_chipselect(bram_chipselect),
        .bram_write(bram_write), .bram_byteenable(bram_byteenable),
        .bram_clken(bram_clken), .bram_readdata(bram_readdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    // BRAM model: RAM stage + output register = two cycles of latency.
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        ram_q         <= mem[bram_address];
        bram_readdata <= ram_q;
    end

    function automatic logic [DW-1:0] pat(input int a);
        logic [DW-1:0] w;
        for (int k = 0; k < 16; k++) begin
            w[k*32 +: 32] = 32'hC0DE_0000 + 32'(a) * 32'h0001_0003 + 32'(k);
        end
        return w;
    endfunction

    // Scoreboard and statistics
    logic [DW:0]   exp_data_q [$];
    logic [AW-1:0] exp_addr_q [$];
    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int cs_count, pop_count, valid_seen, first_cs, last_cs, first_valid;
    int issued, popped;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        cs_count = 0; pop_count = 0; valid_seen = 0;
        first_cs = -1; last_cs = -1; first_valid = -1;
    endtask

    // Mid-cycle monitor: checks reads against the address queue, popped words
    // against the data queue, and the credit invariants every cycle.
    task automatic monitor();
        logic [AW-1:0] ea;
        logic [DW:0]   ed;
        forever begin
            @(negedge clk);
            cycle++;
            if (reset) begin
                issued = 0;
                popped = 0;
            end else begin
                if (bram_chipselect) begin
                    cs_count++;
                    issued++;
                    if (first_cs < 0) first_cs = cycle;
                    last_cs = cycle;
                    checks++;
                    assert (exp_addr_q.size() > 0) else begin
                        errors++;
                        $error("FAIL unexpected_read observed=%0h expected=none", bram_address);
                    end
                    if (exp_addr_q.size() > 0) begin
                        ea = exp_addr_q.pop_front();
                        checks++;
                        assert (bram_address === ea) else begin
                            errors++;
                            $error("FAIL read_addr observed=%0h expected=%0h", bram_address, ea);
                        end
                    end
                end
                checks++;
                assert ((issued - popped) <= DEPTH) else begin
                    errors++;
                    $error("FAIL credit observed=%0d expected<=%0d", issued - popped, DEPTH);
                end
                checks++;
                assert (!(dut.push && (int'(dut.fifo_count) >= DEPTH))) else begin
                    errors++;
                    $error("FAIL push_full observed=%0d expected<%0d", dut.fifo_count, DEPTH);
                end
                if (out_valid) begin
                    valid_seen++;
                    if (first_valid < 0) first_valid = cycle;
                end
                if (out_valid && out_ready) begin
                    pop_count++;
                    popped++;
                    checks++;
                    assert (exp_data_q.size() > 0) else begin
                        errors++;
                        $error("FAIL unexpected_word observed=%0h expected=none", out_data[31:0]);
                    end
                    if (exp_data_q.size() > 0) begin
                        ed = exp_data_q.pop_front();
                        checks++;
                        assert (out_data === ed[DW-1:0]) else begin
                            errors++;
                            $error("FAIL out_data observed=%h expected=%h", out_data, ed[DW-1:0]);
                        end
                        checks++;
                        assert (out_last === ed[DW]) else begin
                            errors++;
                            $error("FAIL out_last observed=%b expected=%b", out_last, ed[DW]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [AW:0] n);
        logic [AW-1:0] ai;
        int t;
        for (int i = 0; i < int'(n); i++) begin
            ai = a + AW'(i);
            exp_addr_q.push_back(ai);
            exp_data_q.push_back({(i == int'(n) - 1), pat(int'(ai))});
        end
        clear_stats();
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = n;
        t = 0;
        while (!cmd_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("handshake_timeout", 64'(t < 20), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        $display("cmd addr=%03h len=%0d accepted at cycle %0d", a, n, cycle);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int t;
        t = 0;
        while ((busy || exp_data_q.size() != 0) && t < max) begin
            @(posedge clk); #1;
            t++;
        end
        chk({tag, "_timeout"}, 64'(t < max), 64'd1);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = pat(i);
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b0;
        clear_stats();
        issued = 0; popped = 0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cs", 64'(bram_chipselect), 64'd0);
        chk("rst_addr", 64'(bram_address), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("tie_write", 64'(bram_write), 64'd0);
        chk("tie_clken", 64'(bram_clken), 64'd1);
        chk("tie_be", 64'(&bram_byteenable), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic 4-word read
        out_ready = 1'b1;
        send_cmd(9'h010, 10'd4);
        wait_idle("basic", 100);
        chk("basic_pops", 64'(pop_count), 64'd4);
        chk("basic_reads", 64'(cs_count), 64'd4);
        chk("basic_consecutive", 64'(last_cs - first_cs), 64'd3);
        chk("basic_latency", 64'(first_valid - first_cs), 64'(RD_LAT + 1));

        // Address wrap
        send_cmd(9'h1FE, 10'd4);
        wait_idle("wrap", 100);
        chk("wrap_pops", 64'(pop_count), 64'd4);

        // Long burst with out_ready held high streams one word per cycle
        send_cmd(9'h080, 10'd12);
        wait_idle("stream", 200);
        chk("stream_pops", 64'(pop_count), 64'd12);
        chk("stream_rate", 64'(last_cs - first_cs), 64'd11);

        // Backpressure: out_ready high one cycle in three
        out_ready = 1'b0;
        send_cmd(9'h020, 10'd16);
        begin
            int t;
            t = 0;
            while ((busy || exp_data_q.size() != 0) && t < 400) begin
                out_ready = (t % 3 == 0);
                @(posedge clk); #1;
                t++;
            end
            chk("bp_timeout", 64'(t < 400), 64'd1);
        end
        out_ready = 1'b1;
        chk("bp_pops", 64'(pop_count), 64'd16);
        chk("bp_reads", 64'(cs_count), 64'd16);

        // Stalled consumer: only DEPTH reads may be outstanding
        out_ready = 1'b0;
        send_cmd(9'h0C0, 10'd8);
        repeat (20) @(posedge clk);
        #1;
        chk("stall_reads", 64'(cs_count), 64'(DEPTH));
        chk("stall_cs_low", 64'(bram_chipselect), 64'd0);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_busy", 64'(busy), 64'd1);
        chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
        out_ready = 1'b1;
        wait_idle("stall", 100);
        chk("stall_pops", 64'(pop_count), 64'd8);
        chk("stall_reads_all", 64'(cs_count), 64'd8);

        // Zero-length command is a no-op
        send_cmd(9'h033, 10'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("zero_reads", 64'(cs_count), 64'd0);
        chk("zero_valid", 64'(valid_seen), 64'd0);
        chk("zero_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        send_cmd(9'h1AB, 10'd1);
        wait_idle("single", 100);
        chk("single_pops", 64'(pop_count), 64'd1);

        // Asynchronous reset in the middle of a long command
        send_cmd(9'h040, 10'd32);
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_cs", 64'(bram_chipselect), 64'd0);
        chk("arst_addr", 64'(bram_address), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_last", 64'(out_last), 64'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        $display("reset asserted mid-command at cycle %0d", cycle);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_stats();
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_no_stale", 64'(valid_seen), 64'd0);
        send_cmd(9'h100, 10'd2);
        wait_idle("post_rst", 100);
        chk("post_rst_pops", 64'(pop_count), 64'd2);
        chk("post_rst_reads", 64'(cs_count), 64'd2);
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_extra", 64'(pop_count), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
